// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment / 74HC595 scanner.
package seg_scan_pkg;

  // Largest digit count the scanner supports; digit indices fit in 4 bits.
  localparam int MAX_DIGITS = 16;

  // Phases of one serial transfer into the 595 pair, plus the dwell phase.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DWELL
  } state_t;

  // Digit-level sequencing phases of the scanner top.
  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_SHIFT,
    SCAN_DWELL
  } scan_state_t;

  // One-hot digit select, inverted for common-anode style drivers.
  function automatic logic [MAX_DIGITS-1:0] sel_mask(input logic [3:0] idx,
                                                     input logic activeLow);
    logic [MAX_DIGITS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return activeLow ? ~m : m;
  endfunction

  // Lowest enabled digit, 0 when nothing is enabled.
  function automatic logic [3:0] first_enabled(input logic [MAX_DIGITS-1:0] en);
    logic [3:0] r;
    r = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (en[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Next enabled digit above cur; bit 4 flags a wrap back to the lowest one.
  function automatic logic [4:0] next_enabled(input logic [MAX_DIGITS-1:0] en,
                                              input logic [3:0] cur);
    logic       found;
    logic [3:0] r;
    found = 1'b0;
    r     = first_enabled(en);
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (en[i] && (4'(i) > cur)) begin
        r     = 4'(i);
        found = 1'b1;
      end
    end
    return {~found, r};
  endfunction

endpackage

// File: rtl/seg_scan_595_hc595_shifter.sv
// Serialises one word MSB-first into a daisy-chained 74HC595 pair and
// pulses the storage latch once the last bit is clocked in.
module hc595_shifter
  import seg_scan_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int CLK_DIV = 2
) (
  input  logic             s_clk,
  input  logic             s_reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic             busy,
  output logic             done,
  output logic             data_out,
  output logic             data_clock,
  output logic             latch_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   bits_q;
  logic [WIDTH-1:0]   sreg_q;
  logic               dataOut_q;
  logic               dataClock_q;
  logic               latch_q;
  logic               divLast;

  assign divLast    = (div_q == DIV_W'(CLK_DIV - 1));
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == LATCH) && divLast;
  assign data_out   = dataOut_q;
  assign data_clock = dataClock_q;
  assign latch_out  = latch_q;

  // Transfer sequencer: word capture, half-period clocking, then latch pulse.
  always_ff @(posedge s_clk) begin
    if (!s_reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bits_q      <= '0;
      sreg_q      <= '0;
      dataOut_q   <= 1'b0;
      dataClock_q <= 1'b0;
      latch_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          sreg_q      <= word;
          bits_q      <= CNT_W'(WIDTH);
          div_q       <= '0;
          dataOut_q   <= word[WIDTH-1];
          dataClock_q <= 1'b0;
          state_q     <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (divLast) begin
            div_q       <= '0;
            dataClock_q <= 1'b1;
            state_q     <= SHIFT_HI;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (divLast) begin
            div_q       <= '0;
            dataClock_q <= 1'b0;
            sreg_q      <= {sreg_q[WIDTH-2:0], 1'b0};
            bits_q      <= bits_q - CNT_W'(1);
            if (bits_q == CNT_W'(1)) begin
              dataOut_q <= 1'b0;
              latch_q   <= 1'b1;
              state_q   <= LATCH;
            end else begin
              dataOut_q <= sreg_q[WIDTH-2];
              state_q   <= SHIFT_LO;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        LATCH: begin
          if (divLast) begin
            div_q   <= '0;
            latch_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_595.sv
// N-digit multiplexed 7-segment scanner: frame snapshot, digit sequencing,
// PWM dwell on the 595 output enable and a frame-done strobe.
module seg_scan_595
  import seg_scan_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SEG_W          = 8,
  parameter int CLK_DIV        = 2,
  parameter int DWELL_UNIT     = 4,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    s_clk,
  input  logic                    s_reset_n,
  input  logic                    scan_en,
  input  logic [DIGITS*SEG_W-1:0] data_in,
  input  logic [DIGITS-1:0]       digit_en,
  input  logic [3:0]              bright,
  output logic                    data_out,
  output logic                    data_clock,
  output logic                    latch_out,
  output logic                    oe_n,
  output logic                    frame_done
);

  localparam int WORD_W = DIGITS + SEG_W;
  localparam int UNIT_W = (DWELL_UNIT > 1) ? $clog2(DWELL_UNIT) : 1;

  scan_state_t               scanState_q;
  logic [DIGITS*SEG_W-1:0]   snapData_q;
  logic [DIGITS-1:0]         snapEn_q;
  logic [3:0]                idx_q;
  logic [UNIT_W-1:0]         unit_q;
  logic [3:0]                step_q;
  logic                      oeN_q;
  logic                      frameDone_q;

  logic [MAX_DIGITS-1:0]     snapEnPad;
  logic [MAX_DIGITS-1:0]     liveEnPad;
  logic [4:0]                nextInfo;
  logic                      dwellLast;
  logic                      startIdle;
  logic                      startNext;
  logic                      shStart;
  logic                      shBusy;
  logic                      shDone;
  logic [WORD_W-1:0]         word;
  logic [UNIT_W-1:0]         unitNext_d;
  logic [3:0]                stepNext_d;

  // Next digit, start request, dwell counter advance and the outgoing word.
  always_comb begin
    snapEnPad = MAX_DIGITS'(snapEn_q);
    liveEnPad = MAX_DIGITS'(digit_en);
    nextInfo  = next_enabled(snapEnPad, idx_q);
    dwellLast = (step_q == 4'd15) && (unit_q == UNIT_W'(DWELL_UNIT - 1));
    startIdle = (scanState_q == SCAN_IDLE) && scan_en && (|digit_en);
    startNext = (scanState_q == SCAN_DWELL) && dwellLast && scan_en &&
                (!nextInfo[4] || (|digit_en));
    shStart   = (startIdle || startNext) && !shBusy;
    if (unit_q == UNIT_W'(DWELL_UNIT - 1)) begin
      unitNext_d = '0;
      stepNext_d = step_q + 4'd1;
    end else begin
      unitNext_d = unit_q + UNIT_W'(1);
      stepNext_d = step_q;
    end
    word = {DIGITS'(sel_mask(idx_q, SEL_ACTIVE_LOW != 0)),
            snapData_q[int'(idx_q)*SEG_W +: SEG_W]};
  end

  // Digit sequencer: snapshot at frame start, dwell with PWM, frame strobe.
  always_ff @(posedge s_clk) begin
    if (!s_reset_n) begin
      scanState_q <= SCAN_IDLE;
      snapData_q  <= '0;
      snapEn_q    <= '0;
      idx_q       <= '0;
      unit_q      <= '0;
      step_q      <= '0;
      oeN_q       <= 1'b1;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      case (scanState_q)
        SCAN_IDLE: begin
          oeN_q <= 1'b1;
          if (shStart) begin
            snapData_q  <= data_in;
            snapEn_q    <= digit_en;
            idx_q       <= first_enabled(liveEnPad);
            scanState_q <= SCAN_SHIFT;
          end
        end
        SCAN_SHIFT: begin
          oeN_q <= 1'b1;
          if (shDone) begin
            unit_q      <= '0;
            step_q      <= '0;
            oeN_q       <= (bright == 4'd0);
            scanState_q <= SCAN_DWELL;
          end
        end
        SCAN_DWELL: begin
          if (dwellLast) begin
            frameDone_q <= nextInfo[4];
            oeN_q       <= 1'b1;
            unit_q      <= '0;
            step_q      <= '0;
            if (nextInfo[4] && scan_en) begin
              snapData_q <= data_in;
              snapEn_q   <= digit_en;
              idx_q      <= first_enabled(liveEnPad);
            end else if (!nextInfo[4]) begin
              idx_q <= nextInfo[3:0];
            end
            scanState_q <= shStart ? SCAN_SHIFT : SCAN_IDLE;
          end else begin
            unit_q <= unitNext_d;
            step_q <= stepNext_d;
            oeN_q  <= !(stepNext_d < bright);
          end
        end
        default: scanState_q <= SCAN_IDLE;
      endcase
    end
  end

  hc595_shifter #(
    .WIDTH   (WORD_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .s_clk      (s_clk),
    .s_reset_n  (s_reset_n),
    .start      (shStart),
    .word       (word),
    .busy       (shBusy),
    .done       (shDone),
    .data_out   (data_out),
    .data_clock (data_clock),
    .latch_out  (latch_out)
  );

  assign oe_n       = oeN_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_595.sv
// Directed bench for seg_scan_595 with default parameters: a behavioural
// 595 model rebuilds latched words, frame strobes and PWM lit time.
module tb_seg_scan_595;

  logic        s_clk     = 1'b0;
  logic        s_reset_n = 1'b0;
  logic        scan_en   = 1'b0;
  logic [47:0] data_in   = '0;
  logic [5:0]  digit_en  = '0;
  logic [3:0]  bright    = '0;
  logic        data_out;
  logic        data_clock;
  logic        latch_out;
  logic        oe_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [13:0] sr        = '0;
  logic        prevClk   = 1'b0;
  logic        prevLatch = 1'b0;
  logic [13:0] wordQ[$];
  int          latchQ[$];
  int          frameQ[$];
  int          frameOeQ[$];
  int          clkRises   = 0;
  int          oeLowTotal = 0;

  typedef struct {
    string       name;
    logic [47:0] data;
    logic [5:0]  en;
    logic [3:0]  bright;
    logic [13:0] w0;
    logic [13:0] w1;
    int          period;
    int          oeLow;
  } vec_t;

  vec_t vecs[5];

  localparam logic [47:0] D_OLD = 48'h66_55_44_33_22_11;
  localparam logic [47:0] D_NEW = 48'hEE_DD_CC_BB_AA_99;

  seg_scan_595 dut (
    .s_clk      (s_clk),
    .s_reset_n  (s_reset_n),
    .scan_en    (scan_en),
    .data_in    (data_in),
    .digit_en   (digit_en),
    .bright     (bright),
    .data_out   (data_out),
    .data_clock (data_clock),
    .latch_out  (latch_out),
    .oe_n       (oe_n),
    .frame_done (frame_done)
  );

  // Free-running system clock, 10 time units per cycle.
  always #5 s_clk = ~s_clk;

  // Cycle counter used to timestamp observed events.
  always @(posedge s_clk) cyc <= cyc + 1;

  // Model of the 595 pair plus observers for latch, oe_n and frame strobes.
  always @(negedge s_clk) begin
    if (data_clock === 1'b1 && !prevClk) begin
      sr = {sr[12:0], data_out};
      clkRises++;
    end
    if (latch_out === 1'b1 && !prevLatch) begin
      wordQ.push_back(sr);
      latchQ.push_back(cyc);
    end
    if (oe_n === 1'b0) oeLowTotal++;
    if (frame_done === 1'b1) begin
      frameQ.push_back(cyc);
      frameOeQ.push_back(oeLowTotal);
    end
    prevClk   = (data_clock === 1'b1);
    prevLatch = (latch_out === 1'b1);
  end

  // Hard stop in case a wait loop is ever left unbounded.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [47:0] d, input logic [5:0] en,
                               input logic [3:0] br, input logic sc);
    data_in  = d;
    digit_en = en;
    bright   = br;
    scan_en  = sc;
  endtask

  task automatic doReset();
    @(negedge s_clk);
    s_reset_n = 1'b0;
    repeat (2) @(negedge s_clk);
    s_reset_n = 1'b1;
  endtask

  task automatic waitWords(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (wordQ.size() < n && k < budget) begin
      @(negedge s_clk);
      k++;
    end
    checkOutput(name, 32'(wordQ.size() >= n), 32'd1);
  endtask

  task automatic waitFrames(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (frameQ.size() < n && k < budget) begin
      @(negedge s_clk);
      k++;
    end
    checkOutput(name, 32'(frameQ.size() >= n), 32'd1);
  endtask

  initial begin
    int bw, bf, bl, base, startCyc, k;

    vecs[0] = '{"full_a5",   48'h0000_0000_00A5, 6'h3F,      4'd15,
                14'b111110_10100101, 14'b111101_00000000, 738, 360};
    vecs[1] = '{"dig2_5",    48'h1234_5678_9ABC, 6'b100100,  4'd15,
                14'b111011_01111000, 14'b011111_00010010, 246, 120};
    vecs[2] = '{"dark",      48'hFF00_FF00_FF00, 6'h3F,      4'd0,
                14'b111110_00000000, 14'b111101_11111111, 738, 0};
    vecs[3] = '{"single_b8", 48'h0000_0000_003C, 6'b000001,  4'd8,
                14'b111110_00111100, 14'b111110_00111100, 123, 32};
    vecs[4] = '{"dig1_4_b1", 48'h007E_0000_8100, 6'b010010,  4'd1,
                14'b111101_10000001, 14'b101111_01111110, 246, 8};

    // Reset state while reset is held.
    repeat (3) @(negedge s_clk);
    checkOutput("reset_outputs", {27'd0, data_out, data_clock, latch_out, oe_n, frame_done},
                32'b00010);
    s_reset_n = 1'b1;

    // No enabled digits: stays idle and dark, then starts once a digit appears.
    applyStimulus(D_OLD, 6'h00, 4'd15, 1'b1);
    repeat (20) @(negedge s_clk);
    checkOutput("noen_no_shift", 32'(clkRises), 32'd0);
    checkOutput("noen_oe_n", {31'd0, oe_n}, 32'd1);
    applyStimulus(D_OLD, 6'h01, 4'd15, 1'b1);
    waitWords(1, 300, "noen_start_timeout");
    checkOutput("noen_first_word", {18'd0, wordQ[0]}, {18'd0, 14'b111110_00010001});

    // Table of steady-state scans.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data, vecs[v].en, vecs[v].bright, 1'b0);
      doReset();
      bw = wordQ.size();
      bf = frameQ.size();
      bl = latchQ.size();
      startCyc = cyc;
      applyStimulus(vecs[v].data, vecs[v].en, vecs[v].bright, 1'b1);
      waitFrames(bf + 2, 3000, {vecs[v].name, "_timeout"});
      if (frameQ.size() >= bf + 2) begin
        checkOutput({vecs[v].name, "_w0"}, {18'd0, wordQ[bw]}, {18'd0, vecs[v].w0});
        checkOutput({vecs[v].name, "_w1"}, {18'd0, wordQ[bw+1]}, {18'd0, vecs[v].w1});
        checkOutput({vecs[v].name, "_latch_at"}, 32'(latchQ[bl] - (startCyc + 1)), 32'd57);
        checkOutput({vecs[v].name, "_first_frame"}, 32'(frameQ[bf] - (startCyc + 1)),
                    32'(vecs[v].period));
        checkOutput({vecs[v].name, "_period"}, 32'(frameQ[bf+1] - frameQ[bf]),
                    32'(vecs[v].period));
        checkOutput({vecs[v].name, "_oe_low"}, 32'(frameOeQ[bf+1] - frameOeQ[bf]),
                    32'(vecs[v].oeLow));
      end
    end

    // Data change during digit 3: rest of the frame keeps the old snapshot.
    applyStimulus(D_OLD, 6'h3F, 4'd15, 1'b0);
    doReset();
    bw = wordQ.size();
    applyStimulus(D_OLD, 6'h3F, 4'd15, 1'b1);
    waitWords(bw + 4, 1000, "tear_wait_d3");
    applyStimulus(D_NEW, 6'h3F, 4'd15, 1'b1);
    waitWords(bw + 12, 2000, "tear_wait_frame2");
    checkOutput("tear_d3_old", {18'd0, wordQ[bw+3]},  {18'd0, 14'b110111_01000100});
    checkOutput("tear_d4_old", {18'd0, wordQ[bw+4]},  {18'd0, 14'b101111_01010101});
    checkOutput("tear_d5_old", {18'd0, wordQ[bw+5]},  {18'd0, 14'b011111_01100110});
    checkOutput("tear_d0_new", {18'd0, wordQ[bw+6]},  {18'd0, 14'b111110_10011001});
    checkOutput("tear_d5_new", {18'd0, wordQ[bw+11]}, {18'd0, 14'b011111_11101110});

    // scan_en dropped while digit 1 shifts: digit 1 completes, then idle.
    applyStimulus(D_OLD, 6'h3F, 4'd15, 1'b0);
    doReset();
    bw   = wordQ.size();
    bf   = frameQ.size();
    base = clkRises;
    applyStimulus(D_OLD, 6'h3F, 4'd15, 1'b1);
    k = 0;
    while (clkRises < base + 16 && k < 500) begin
      @(negedge s_clk);
      k++;
    end
    checkOutput("stop_reach_d1", 32'(clkRises >= base + 16), 32'd1);
    scan_en = 1'b0;
    waitWords(bw + 2, 500, "stop_wait_d1");
    repeat (300) @(negedge s_clk);
    checkOutput("stop_d1_word", {18'd0, wordQ[bw+1]}, {18'd0, 14'b111101_00100010});
    checkOutput("stop_word_count", 32'(wordQ.size() - bw), 32'd2);
    checkOutput("stop_clk_rises", 32'(clkRises - base), 32'd28);
    checkOutput("stop_oe_n", {31'd0, oe_n}, 32'd1);
    checkOutput("stop_data_clock", {31'd0, data_clock}, 32'd0);
    checkOutput("stop_no_frame", 32'(frameQ.size() - bf), 32'd0);
    scan_en = 1'b1;
    waitWords(bw + 3, 500, "resume_timeout");
    checkOutput("resume_d0_word", {18'd0, wordQ[bw+2]}, {18'd0, 14'b111110_00010001});

    // Reset during SHIFT_HI aborts at once with no latch pulse.
    applyStimulus(D_OLD, 6'h3F, 4'd15, 1'b0);
    doReset();
    base = clkRises;
    applyStimulus(D_OLD, 6'h3F, 4'd15, 1'b1);
    k = 0;
    while (!(data_clock === 1'b1 && clkRises >= base + 5) && k < 200) begin
      @(negedge s_clk);
      k++;
    end
    checkOutput("rst_reach_shift_hi", {31'd0, data_clock}, 32'd1);
    bl = latchQ.size();
    s_reset_n = 1'b0;
    @(negedge s_clk);
    checkOutput("rst_mid_outputs", {27'd0, data_out, data_clock, latch_out, oe_n, frame_done},
                32'b00010);
    repeat (3) @(negedge s_clk);
    checkOutput("rst_no_latch", 32'(latchQ.size() - bl), 32'd0);
    s_reset_n = 1'b1;

    // A reset pulse that never spans a clock edge is ignored.
    base = clkRises;
    bw   = wordQ.size();
    bl   = latchQ.size();
    k = 0;
    while (clkRises < base + 3 && k < 200) begin
      @(negedge s_clk);
      k++;
    end
    @(posedge s_clk);
    #2 s_reset_n = 1'b0;
    #2 s_reset_n = 1'b1;
    waitWords(bw + 1, 300, "glitch_timeout");
    checkOutput("glitch_word", {18'd0, wordQ[bw]}, {18'd0, 14'b111110_00010001});
    checkOutput("glitch_clk_rises", 32'(clkRises - base), 32'd14);
    checkOutput("glitch_latches", 32'(latchQ.size() - bl), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
